// File: rtl/raster_dispatcher.sv
// raster_dispatcher: triangle scheduler in front of the rasterizer core.
// Queues triangle_setup_t records in a small FIFO, presents the head record
// to the rasterizer for the whole rasterization, pulses start, waits for done,
// retires the entry and discards invalid / empty-bbox triangles unissued.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_tri/s_valid/s_ready  triangle input from setup stage
//   flush               drop queued, not-yet-issued triangles
//   r_tri/r_start/r_done   rasterizer interface (r_tri = FIFO head)
//   r_frag_valid/ready  monitored fragment handshake
//   idle, q_level       status
//   tri_count, frag_count, skip_count, protocol_err  statistics

package raster_dispatcher_pkg;
    localparam int unsigned COORD_W = 12;
    localparam int unsigned ATTR_W  = 32;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] min_x;
        logic [COORD_W-1:0] max_x;
        logic [COORD_W-1:0] min_y;
        logic [COORD_W-1:0] max_y;
        logic [ATTR_W-1:0]  attr;
    } triangle_setup_t;
endpackage

module raster_dispatcher
    import raster_dispatcher_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  triangle_setup_t               s_tri,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          flush,
    output triangle_setup_t               r_tri,
    output logic                          r_start,
    input  logic                          r_done,
    input  logic                          r_frag_valid,
    input  logic                          r_frag_ready,
    output logic                          idle,
    output logic [$clog2(FIFO_DEPTH):0]   q_level,
    output logic [CNT_W-1:0]              tri_count,
    output logic [CNT_W-1:0]              frag_count,
    output logic [15:0]                   skip_count,
    output logic                          protocol_err
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RETIRE    = 2'd3
    } state_t;

    state_t          state;
    triangle_setup_t mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;

    logic full;
    logic empty;
    logic push;
    logic head_bad;
    logic skip;
    logic retire;
    logic pop;

    // FIFO status and handshake decode
    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign s_ready = !full && !flush;
    assign push    = s_valid && s_ready;
    assign r_tri   = mem[rd_ptr];
    assign q_level = level;
    assign idle    = empty && (state == IDLE);

    // Head is discarded if not valid or its bounding box is empty
    assign head_bad = !r_tri.valid || (r_tri.min_x > r_tri.max_x) ||
                      (r_tri.min_y > r_tri.max_y);
    // A flush in IDLE empties the queue, so it pre-empts the skip
    assign skip     = (state == IDLE) && !empty && head_bad && !flush;
    assign retire   = (state == RETIRE);
    assign pop      = skip || retire;

    // Controller, FIFO pointers and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level        <= '0;
            r_start      <= 1'b0;
            tri_count    <= '0;
            frag_count   <= '0;
            skip_count   <= '0;
            protocol_err <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            r_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (!empty && !head_bad && !flush) begin
                        state   <= ISSUE;
                        r_start <= 1'b1;
                    end
                end
                ISSUE:     state <= WAIT_DONE;
                WAIT_DONE: if (r_done) state <= RETIRE;
                RETIRE:    state <= IDLE;
                default:   state <= IDLE;
            endcase

            if (r_done && (state != WAIT_DONE)) begin
                protocol_err <= 1'b1;
            end

            if (skip && (skip_count != 16'hFFFF)) begin
                skip_count <= skip_count + 16'd1;
            end

            if (retire) begin
                tri_count <= tri_count + CNT_W'(1);
            end

            if (r_frag_valid && r_frag_ready) begin
                frag_count <= frag_count + CNT_W'(1);
            end

            if (push) begin
                mem[wr_ptr] <= s_tri;
            end

            // Flush keeps only the in-flight head; push is blocked meanwhile
            if (flush) begin
                case (state)
                    IDLE: begin
                        rd_ptr <= wr_ptr;
                        level  <= '0;
                    end
                    RETIRE: begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                        wr_ptr <= rd_ptr + PTR_W'(1);
                        level  <= '0;
                    end
                    default: begin
                        wr_ptr <= rd_ptr + PTR_W'(1);
                        level  <= LVL_W'(1);
                    end
                endcase
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                level <= level + LVL_W'(push) - LVL_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_raster_dispatcher.sv
// tb_raster_dispatcher: self-checking bench for raster_dispatcher.
// A transaction-level model keeps the expected triangle order in a queue;
// a rasterizer model answers r_start with r_done after a set latency and
// checks the presented record is the expected one and stays stable.
module tb_raster_dispatcher;
    import raster_dispatcher_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    triangle_setup_t s_tri;
    logic            s_valid;
    logic            s_ready;
    logic            flush;
    triangle_setup_t r_tri;
    logic            r_start;
    logic            r_done;
    logic            rast_done;
    logic            inj_done;
    logic            r_frag_valid;
    logic            r_frag_ready;
    logic            idle;
    logic [2:0]      q_level;
    logic [31:0]     tri_count;
    logic [31:0]     frag_count;
    logic [15:0]     skip_count;
    logic            protocol_err;

    assign r_done = rast_done | inj_done;

    raster_dispatcher #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .s_tri(s_tri), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .r_tri(r_tri), .r_start(r_start), .r_done(r_done),
        .r_frag_valid(r_frag_valid), .r_frag_ready(r_frag_ready), .idle(idle),
        .q_level(q_level), .tri_count(tri_count), .frag_count(frag_count),
        .skip_count(skip_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    triangle_setup_t exp_q[$];
    int exp_tri = 0, exp_skip = 0, exp_frag = 0, exp_perr = 0;
    int n_checks = 0, n_fail = 0;

    // Rasterizer model controls / observations
    int rast_lat = 10;
    bit rast_rand = 0, rast_kill = 0, rast_busy = 0;
    bit have_done = 0, spacing_chk = 0;
    int n_starts = 0, last_start_cyc = 0, last_done_cyc = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit tri_bad(input triangle_setup_t t);
        return !t.valid || (t.min_x > t.max_x) || (t.min_y > t.max_y);
    endfunction

    // kind: 0 good, 1 invalid, 2 empty in x, 3 empty in y
    function automatic triangle_setup_t make_tri(input int kind);
        triangle_setup_t t;
        logic [COORD_W-1:0] a, b, c, d;
        a = COORD_W'($urandom_range(0, 3000));
        b = a + COORD_W'($urandom_range(0, 900));
        c = COORD_W'($urandom_range(0, 3000));
        d = c + COORD_W'($urandom_range(0, 900));
        t.valid = 1'b1;
        t.min_x = a; t.max_x = b; t.min_y = c; t.max_y = d;
        t.attr  = $urandom;
        case (kind)
            1: t.valid = 1'b0;
            2: begin t.min_x = b + COORD_W'(1); t.max_x = a; end
            3: begin t.min_y = d + COORD_W'(1); t.max_y = c; end
            default: ;
        endcase
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tri(input triangle_setup_t t);
        int g = 0;
        while (!s_ready && g < 300) begin
            step();
            g++;
        end
        if (!s_ready) begin
            check_eq("push_timeout", s_ready, 1);
            return;
        end
        s_tri   = t;
        s_valid = 1'b1;
        exp_q.push_back(t);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int g = 0;
        while (!rast_busy && g < 100) begin
            step();
            g++;
        end
        check_eq({tag, "_busy"}, rast_busy, 1);
    endtask

    // Wait for the dispatcher to drain, then compare all statistics
    task automatic wait_quiet(input string tag);
        int g = 0;
        while ((!idle || rast_busy) && g < 2000) begin
            step();
            g++;
        end
        check_eq({tag, "_idle"}, idle, 1);
        // anything left in the model must have been discarded by the DUT
        foreach (exp_q[i]) if (tri_bad(exp_q[i])) exp_skip++;
        exp_q.delete();
        check_eq({tag, "_tri_count"}, tri_count, 128'(exp_tri));
        check_eq({tag, "_skip_count"}, skip_count, 128'(exp_skip));
        check_eq({tag, "_frag_count"}, frag_count, 128'(exp_frag));
        check_eq({tag, "_q_level"}, q_level, 0);
        check_eq({tag, "_protocol_err"}, protocol_err, 128'(exp_perr));
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_s_ready"}, s_ready, 1);
        check_eq({tag, "_idle"}, idle, 1);
        check_eq({tag, "_q_level"}, q_level, 0);
        check_eq({tag, "_r_start"}, r_start, 0);
        check_eq({tag, "_tri_count"}, tri_count, 0);
        check_eq({tag, "_frag_count"}, frag_count, 0);
        check_eq({tag, "_skip_count"}, skip_count, 0);
        check_eq({tag, "_protocol_err"}, protocol_err, 0);
        check_eq({tag, "_r_tri"}, r_tri, 0);
    endtask

    // Rasterizer model
    initial begin : rasterizer
        triangle_setup_t held;
        int lat;
        rast_done = 1'b0;
        forever begin
            step();
            if (r_start && !rast_kill) begin
                n_starts++;
                last_start_cyc = cyc;
                rast_busy = 1'b1;
                if (spacing_chk && have_done)
                    check_eq("start_spacing", 128'(cyc - last_done_cyc), 3);
                while (exp_q.size() > 0 && tri_bad(exp_q[0])) begin
                    void'(exp_q.pop_front());
                    exp_skip++;
                end
                if (exp_q.size() == 0) begin
                    check_eq("start_without_work", r_start, 0);
                    held = r_tri;
                end else begin
                    held = exp_q.pop_front();
                    check_eq("r_tri_issue", r_tri, held);
                end
                lat = rast_rand ? int'($urandom_range(1, 8)) : rast_lat;
                for (int i = 0; i < lat; i++) begin
                    step();
                    if (rast_kill) break;
                    check_eq("r_tri_stable", r_tri, held);
                end
                if (!rast_kill) begin
                    rast_done = 1'b1;
                    last_done_cyc = cyc;
                    have_done = 1'b1;
                    exp_tri++;
                    step();
                    rast_done = 1'b0;
                end
                rast_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        triangle_setup_t t;
        int p, g, hs, starts0;

        rst = 1'b1; s_valid = 1'b0; s_tri = '0; flush = 1'b0; inj_done = 1'b0;
        r_frag_valid = 1'b0; r_frag_ready = 1'b0;
        step(); step();
        check_reset("reset");
        rst = 1'b0;
        step();

        // Single triangle, bbox (0,0)-(3,3), 20-cycle rasterization
        rast_lat = 20;
        t = make_tri(0);
        t.min_x = 0; t.max_x = 3; t.min_y = 0; t.max_y = 3;
        starts0 = n_starts;
        p = cyc;
        push_tri(t);
        g = 0;
        while (n_starts == starts0 && g < 50) begin step(); g++; end
        check_eq("single_start_latency", 128'(last_start_cyc - p), 2);
        wait_quiet("single");

        // Fill the FIFO; back-to-back issue spacing
        rast_lat = 10; have_done = 0; spacing_chk = 1;
        for (int i = 0; i < 4; i++) push_tri(make_tri(0));
        check_eq("fill_s_ready", s_ready, 0);
        check_eq("fill_q_level", q_level, 4);
        wait_quiet("fill");
        spacing_chk = 0;

        // Invalid and empty-bbox triangles are skipped
        starts0 = n_starts;
        push_tri(make_tri(1));
        t = make_tri(0);
        t.min_x = 5; t.max_x = 2;
        push_tri(t);
        push_tri(make_tri(0));
        wait_quiet("skip");
        check_eq("skip_one_start", 128'(n_starts - starts0), 1);

        // Fragment handshakes with ready toggling
        hs = 0; g = 0;
        while (hs < 7 && g < 300) begin
            r_frag_valid = 1'($urandom_range(0, 1));
            r_frag_ready = ~r_frag_ready;
            if (r_frag_valid && r_frag_ready) begin hs++; exp_frag++; end
            step();
            g++;
        end
        r_frag_valid = 1'b0; r_frag_ready = 1'b0;
        step();
        check_eq("frag_count_7", frag_count, 128'(exp_frag));
        wait_quiet("frag");

        // Flush during WAIT_DONE keeps only the in-flight head
        rast_lat = 30;
        for (int i = 0; i < 3; i++) push_tri(make_tri(0));
        wait_busy("flush");
        step(); step();
        check_eq("flush_pre_level", q_level, 3);
        flush = 1'b1;
        #1;
        check_eq("flush_s_ready", s_ready, 0);
        step();
        flush = 1'b0;
        check_eq("flush_post_level", q_level, 1);
        exp_q.delete();
        wait_quiet("flush");

        // Randomized soak: mixed good/bad triangles, random gaps and latency
        rast_rand = 1;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            push_tri(make_tri(r < 7 ? 0 : r - 6));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_quiet("soak");
        rast_rand = 0;

        // r_done while idle: sticky protocol error, no retire
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        exp_perr = 1;
        check_eq("perr_set", protocol_err, 1);
        step(); step(); step();
        check_eq("perr_sticky", protocol_err, 1);
        check_eq("perr_tri_count", tri_count, 128'(exp_tri));

        // Reset in the middle of WAIT_DONE
        rast_lat = 200;
        push_tri(make_tri(0));
        push_tri(make_tri(0));
        wait_busy("midrst");
        step(); step(); step();
        rast_kill = 1'b1;
        rst = 1'b1;
        step();
        check_reset("midrst");
        rst = 1'b0;
        step(); step();
        rast_kill = 1'b0;
        exp_q.delete();
        exp_tri = 0; exp_skip = 0; exp_frag = 0; exp_perr = 0;

        // Normal operation after reset
        rast_lat = 5;
        push_tri(make_tri(0));
        wait_quiet("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/raster_dispatcher.md
Name: raster_dispatcher

Overview:
- Triangle scheduler in front of the rasterizer core.
- Buffers incoming triangle_setup_t records in a small FIFO and presents the head record to the rasterizer, stable for the whole rasterization.
- Pulses the rasterizer start, waits for its done pulse, retires the entry, and discards invalid or empty-bounding-box triangles without issuing them.
- Keeps triangle, fragment and skip statistics for the host/debug path.

Parameters:
- FIFO_DEPTH, 4, number of queued triangles; power of two, 2..16.
- CNT_W, 32, width of the triangle and fragment counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_tri  in  $bits(triangle_setup_t)  triangle from setup stage.
- s_valid  in  1  s_tri valid.
- s_ready  out  1  FIFO can accept this cycle.
- flush  in  1  drop all queued, not-yet-issued triangles.
- r_tri  out  $bits(triangle_setup_t)  record to rasterizer tri_in.
- r_start  out  1  one-cycle start pulse to rasterizer.
- r_done  in  1  rasterizer done pulse.
- r_frag_valid  in  1  rasterizer fragment valid (monitored only).
- r_frag_ready  in  1  downstream fragment ready (monitored only).
- idle  out  1  FIFO empty and controller in IDLE.
- q_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- tri_count  out  CNT_W  triangles retired.
- frag_count  out  CNT_W  fragments accepted downstream.
- skip_count  out  16  triangles discarded without issue.
- protocol_err  out  1  sticky; r_done seen outside WAIT_DONE.

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFO empty, state IDLE, all counters 0, protocol_err 0, r_start 0.
  - s_ready=1, idle=1, q_level=0.
  - r_tri = FIFO head storage, driven 0 after reset.
- FIFO:
  - Push when s_valid && s_ready; s_ready = !full && !flush.
  - Pop only from the controller, and only on RETIRE or skip.
  - Push and pop in the same cycle is legal; level is unchanged.
  - q_level is registered and reflects pushes/pops on the next cycle.
  - r_tri is combinationally the head entry.
- States:
  - IDLE: if FIFO non-empty, examine head:
    - If head.valid==0 or min_x>max_x or min_y>max_y: pop, skip_count++ (saturates at 16'hFFFF), stay IDLE. At most one skip per cycle.
    - Otherwise go to ISSUE.
  - ISSUE: r_start=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: hold; on r_done=1 go to RETIRE.
  - RETIRE: pop head, tri_count++ (wraps); go to IDLE.
- Timing and latency:
  - Push into an empty idle block at cycle N gives r_start high at cycle N+2.
  - Back-to-back issue: done at cycle D, RETIRE at D+1, IDLE at D+2, next r_start at D+3. The rasterizer is in its IDLE by then.
- r_tri stability: the head must not change from ISSUE through RETIRE. The rasterizer reads tri_in continuously during rasterization.
- frag_count: increments every cycle with r_frag_valid && r_frag_ready, in any state; wraps.
- protocol_err: set when r_done=1 while state != WAIT_DONE; that r_done is otherwise ignored. Cleared only by rst.
- flush:
  - In IDLE: FIFO emptied next cycle.
  - In ISSUE/WAIT_DONE/RETIRE: all entries except the head are dropped. The in-flight triangle completes and retires normally.
  - Flushed entries are not counted in skip_count.
  - Push is blocked during flush (s_ready=0).
- Simultaneous events:
  - flush and skip in the same IDLE cycle: flush wins; skip_count is not incremented.
  - frag handshake and RETIRE in the same cycle: both counters update.
- Reset mid-operation: all state is discarded immediately, with no retire or count update. The rasterizer must be reset alongside the dispatcher.

Test Plan:
- Single triangle, bbox (0,0)-(3,3), valid=1: push at cycle 0 -> r_start at cycle 2; model done 20 cycles later -> tri_count=1, q_level=0, idle=1.
- Fill 4 triangles with a 10-cycle rasterizer model: s_ready=0 after 4 pushes; r_tri constant from ISSUE until each RETIRE; starts spaced done+3; final tri_count=4.
- Push valid=0 triangle, then min_x=5,max_x=2 triangle, then a good one -> skip_count=2, exactly one r_start, tri_count=1.
- 7 fragment handshakes with r_frag_ready toggled 50% -> frag_count equals accepted handshakes exactly (7 valid-ready coincidences).
- 3 queued, flush asserted during WAIT_DONE -> q_level=1 next cycle; in-flight triangle retires; tri_count=1; skip_count=0.
- r_done pulsed while IDLE -> protocol_err=1 and sticky, tri_count unchanged; rst mid-WAIT_DONE -> all outputs return to their reset values the next cycle.
